wb_arbiter_2m: RTL and testbench

Two-master Wishbone classic arbiter sharing one slave (the single-port SRAM Wishbone wrapper) between the core's instruction-fetch and data ports. Grants are round-robin and held for a whole `cyc` burst. A per-transfer watchdog returns `err` to a master whose strobe is left unacknowledged. The block sits between the two CPU bus masters and the SRAM slave port.

---
 rtl/wb_arbiter_2m_pkg.sv | 19 +
 rtl/wb_rr_grant2.sv | 65 ++++++
 rtl/wb_arbiter_2m.sv | 121 ++++++++++++
 tb/tb_wb_arbiter_2m.sv | 418 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_arbiter_2m_pkg.sv
// ---------------------------------------------------------------
// wb_arbiter_2m_pkg : shared encodings for the 2-master arbiter
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

package wb_arbiter_2m_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_GNT0 = 2'd1;
  localparam logic [1:0] ST_GNT1 = 2'd2;

  // Master indices; m0 is instruction fetch, m1 is data.
  localparam logic MST0 = 1'b0;
  localparam logic MST1 = 1'b1;

endpackage

`default_nettype wire

// File: rtl/wb_rr_grant2.sv
// ---------------------------------------------------------------
// wb_rr_grant2 : round-robin grant FSM, grant held for a whole cyc
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module wb_rr_grant2
  import wb_arbiter_2m_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] cyc,
  output logic [1:0] gnt
);

  logic [1:0] state_q, state_d;
  logic       last_q, last_d;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      last_q  <= MST1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    case (state_q)
      ST_IDLE: begin
        // On a tie the master that was not served last wins.
        if (cyc[MST0] && (!cyc[MST1] || (last_q == MST1))) begin
          state_d = ST_GNT0;
        end else if (cyc[MST1]) begin
          state_d = ST_GNT1;
        end
      end
      ST_GNT0: begin
        if (!cyc[MST0]) begin
          last_d  = MST0;
          state_d = cyc[MST1] ? ST_GNT1 : ST_IDLE;
        end
      end
      ST_GNT1: begin
        if (!cyc[MST1]) begin
          last_d  = MST1;
          state_d = cyc[MST0] ? ST_GNT0 : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    gnt       = 2'b00;
    gnt[MST0] = (state_q == ST_GNT0);
    gnt[MST1] = (state_q == ST_GNT1);
  end

endmodule

`default_nettype wire

// File: rtl/wb_arbiter_2m.sv
// ---------------------------------------------------------------
// wb_arbiter_2m : two-master Wishbone classic arbiter with watchdog
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module wb_arbiter_2m
  import wb_arbiter_2m_pkg::*;
#(
  parameter int addr_width     = 32,
  parameter int data_width     = 32,
  parameter int strobe_width   = data_width / 8,
  parameter int timeout_cycles = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [addr_width-1:0]   m0_adr,
  input  logic [data_width-1:0]   m0_datwr,
  input  logic                    m0_we,
  input  logic                    m0_stb,
  input  logic                    m0_cyc,
  input  logic [strobe_width-1:0] m0_sel,
  output logic [data_width-1:0]   m0_datrd,
  output logic                    m0_ack,
  output logic                    m0_err,
  input  logic [addr_width-1:0]   m1_adr,
  input  logic [data_width-1:0]   m1_datwr,
  input  logic                    m1_we,
  input  logic                    m1_stb,
  input  logic                    m1_cyc,
  input  logic [strobe_width-1:0] m1_sel,
  output logic [data_width-1:0]   m1_datrd,
  output logic                    m1_ack,
  output logic                    m1_err,
  output logic [addr_width-1:0]   s_adr,
  output logic [data_width-1:0]   s_datwr,
  output logic                    s_we,
  output logic                    s_stb,
  output logic                    s_cyc,
  output logic [strobe_width-1:0] s_sel,
  input  logic [data_width-1:0]   s_datrd,
  input  logic                    s_ack
);

  logic [1:0] gnt;
  logic       own_stb;
  logic       wdog_err;

  wb_rr_grant2 u_grant (
    .clock (clock),
    .reset (reset),
    .cyc   ({m1_cyc, m0_cyc}),
    .gnt   (gnt)
  );

  always_comb begin
    s_adr   = '0;
    s_datwr = '0;
    s_we    = 1'b0;
    s_sel   = '0;
    s_cyc   = 1'b0;
    own_stb = 1'b0;
    if (gnt[MST0]) begin
      s_adr   = m0_adr;
      s_datwr = m0_datwr;
      s_we    = m0_we;
      s_sel   = m0_sel;
      s_cyc   = m0_cyc;
      own_stb = m0_stb;
    end else if (gnt[MST1]) begin
      s_adr   = m1_adr;
      s_datwr = m1_datwr;
      s_we    = m1_we;
      s_sel   = m1_sel;
      s_cyc   = m1_cyc;
      own_stb = m1_stb;
    end
    // The timed-out strobe is withdrawn so the slave cannot ack alongside err.
    s_stb = own_stb & ~wdog_err;
  end

  assign m0_ack   = s_ack & gnt[MST0] & m0_stb;
  assign m1_ack   = s_ack & gnt[MST1] & m1_stb;
  assign m0_err   = wdog_err & gnt[MST0];
  assign m1_err   = wdog_err & gnt[MST1];
  assign m0_datrd = s_datrd;
  assign m1_datrd = s_datrd;

  if (timeout_cycles > 0) begin : g_wdog
    localparam int CW = $clog2(timeout_cycles + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          hit;

    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    // s_cyc low covers both IDLE and the cycle a grant is being released.
    always_comb begin
      hit   = own_stb && (cnt_q == CW'(timeout_cycles));
      cnt_d = cnt_q;
      if (!s_cyc || s_ack || hit) begin
        cnt_d = '0;
      end else if (own_stb) begin
        cnt_d = cnt_q + CW'(1);
      end
    end

    assign wdog_err = hit;
  end else begin : g_no_wdog
    assign wdog_err = 1'b0;
  end

endmodule

`default_nettype wire

// File: tb/tb_wb_arbiter_2m.sv
// ---------------------------------------------------------------
// tb_wb_arbiter_2m : self-checking bench for wb_arbiter_2m
// Rev 1.0
// ---------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_wb_arbiter_2m;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int SW  = 4;
  localparam int TMO = 16;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [AW-1:0] m0_adr, m1_adr, s_adr;
  logic [DW-1:0] m0_datwr, m1_datwr, m0_datrd, m1_datrd, s_datwr, s_datrd;
  logic          m0_we, m1_we, m0_stb, m1_stb, m0_cyc, m1_cyc;
  logic [SW-1:0] m0_sel, m1_sel, s_sel;
  logic          m0_ack, m1_ack, m0_err, m1_err;
  logic          s_we, s_stb, s_cyc, s_ack;

  int n_checks = 0;
  int n_pass   = 0;

  wb_arbiter_2m #(
    .addr_width(AW), .data_width(DW), .strobe_width(SW), .timeout_cycles(TMO)
  ) dut (
    .clock(clock), .reset(reset),
    .m0_adr(m0_adr), .m0_datwr(m0_datwr), .m0_we(m0_we), .m0_stb(m0_stb),
    .m0_cyc(m0_cyc), .m0_sel(m0_sel), .m0_datrd(m0_datrd), .m0_ack(m0_ack), .m0_err(m0_err),
    .m1_adr(m1_adr), .m1_datwr(m1_datwr), .m1_we(m1_we), .m1_stb(m1_stb),
    .m1_cyc(m1_cyc), .m1_sel(m1_sel), .m1_datrd(m1_datrd), .m1_ack(m1_ack), .m1_err(m1_err),
    .s_adr(s_adr), .s_datwr(s_datwr), .s_we(s_we), .s_stb(s_stb), .s_cyc(s_cyc),
    .s_sel(s_sel), .s_datrd(s_datrd), .s_ack(s_ack)
  );

  always #5 clock = ~clock;

  // SRAM-style slave: ack one cycle after stb&cyc, one beat every other cycle.
  logic [DW-1:0] mem [64];
  logic          slv_en = 1'b1;
  logic          slv_ack_q;
  logic [DW-1:0] slv_rd_q;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      slv_ack_q <= 1'b0;
      slv_rd_q  <= '0;
      for (int i = 0; i < 64; i++) mem[i] <= '0;
    end else begin
      slv_ack_q <= slv_en && s_cyc && s_stb && !slv_ack_q;
      if (slv_en && s_cyc && s_stb && !slv_ack_q) begin
        slv_rd_q <= mem[s_adr[5:0]];
        if (s_we)
          for (int b = 0; b < SW; b++)
            if (s_sel[b]) mem[s_adr[5:0]][8*b +: 8] <= s_datwr[8*b +: 8];
      end
    end
  end

  assign s_ack   = slv_ack_q;
  assign s_datrd = slv_rd_q;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic mid();
    @(negedge clock);
  endtask

  task automatic idle_masters();
    m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_sel = '0; m0_adr = '0; m0_datwr = '0;
    m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_sel = '0; m1_adr = '0; m1_datwr = '0;
  endtask

  task automatic do_reset();
    idle_masters();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    logic [11:0] obs;
    // Requests present during reset must not reach the slave.
    m0_cyc = 1; m0_stb = 1; m0_we = 1; m0_sel = 4'hF;
    m1_cyc = 1; m1_stb = 1; m1_we = 1; m1_sel = 4'hF;
    reset = 1'b0;
    tick();
    mid();
    obs = {s_cyc, s_stb, s_we, s_sel, m0_ack, m1_ack, m0_err, m1_err, 1'b0};
    n_checks++;
    if (obs !== 12'h0) $display("FAIL reset_outputs: got %h expected %h", obs, 12'h0);
    else n_pass++;
    tick();
    idle_masters();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_single();
    logic [71:0] obs;
    tick();
    m0_cyc = 1; m0_stb = 1; m0_we = 1; m0_adr = 5; m0_datwr = 32'hDEADBEEF; m0_sel = 4'hF;
    mid();
    n_checks++;
    if (s_cyc !== 1'b0) $display("FAIL single_scyc_t0: got %b expected 0", s_cyc);
    else n_pass++;
    tick(); mid();
    obs = {s_cyc, s_stb, s_we, 1'b0, s_sel, s_adr, s_datwr};
    n_checks++;
    if (obs !== {4'b1110, 4'hF, 32'd5, 32'hDEADBEEF} || m0_ack !== 1'b0)
      $display("FAIL single_mux_t1: got %h ack %b expected %h ack 0", obs, m0_ack,
               {4'b1110, 4'hF, 32'd5, 32'hDEADBEEF});
    else n_pass++;
    tick(); mid();
    n_checks++;
    if ({m0_ack, m1_ack} !== 2'b10) $display("FAIL single_wr_ack_t2: got %b expected 10", {m0_ack, m1_ack});
    else n_pass++;
    tick();
    m0_cyc = 0; m0_stb = 0; m0_we = 0;
    tick();
    m0_cyc = 1; m0_stb = 1; m0_datwr = '0;
    tick(); tick(); mid();
    n_checks++;
    if ({m0_ack, m1_ack, m0_datrd} !== {2'b10, 32'hDEADBEEF})
      $display("FAIL single_readback: got ack %b%b data %h expected 10 deadbeef", m0_ack, m1_ack, m0_datrd);
    else n_pass++;
    tick();
    idle_masters();
    tick();
  endtask

  task automatic test_simultaneous();
    do_reset();
    tick();
    m0_cyc = 1; m0_stb = 1; m0_adr = 32'h10;
    m1_cyc = 1; m1_stb = 1; m1_adr = 32'h20;
    tick(); mid();
    n_checks++;
    if ({s_cyc, s_adr} !== {1'b1, 32'h10}) $display("FAIL sim_first_gnt: got %b %h expected 1 10", s_cyc, s_adr);
    else n_pass++;
    tick(); mid();
    n_checks++;
    if ({m0_ack, m1_ack} !== 2'b10) $display("FAIL sim_m0_ack: got %b expected 10", {m0_ack, m1_ack});
    else n_pass++;
    tick();
    m0_cyc = 0; m0_stb = 0;
    mid();
    n_checks++;
    if (s_cyc !== 1'b0) $display("FAIL sim_gap: got %b expected 0", s_cyc);
    else n_pass++;
    tick(); mid();
    n_checks++;
    if ({s_cyc, s_adr} !== {1'b1, 32'h20}) $display("FAIL sim_handoff: got %b %h expected 1 20", s_cyc, s_adr);
    else n_pass++;
    tick(); mid();
    n_checks++;
    if ({m0_ack, m1_ack} !== 2'b01) $display("FAIL sim_m1_ack: got %b expected 01", {m0_ack, m1_ack});
    else n_pass++;
    tick();
    idle_masters();
    tick();
  endtask

  task automatic test_round_robin();
    int  got;
    int  budget;
    logic a0, a1;
    do_reset();
    got = 0;
    budget = 200;
    tick();
    m0_cyc = 1; m0_stb = 1; m0_adr = $urandom_range(0, 31);
    m1_cyc = 1; m1_stb = 1; m1_adr = $urandom_range(32, 63);
    while (got < 8 && budget > 0) begin
      mid();
      a0 = m0_ack;
      a1 = m1_ack;
      if (a0) begin
        n_checks++;
        if (got % 2 != 0) $display("FAIL rr_order: ack %0d went to m0 expected m1", got);
        else n_pass++;
        got++;
      end
      if (a1) begin
        n_checks++;
        if (got % 2 != 1) $display("FAIL rr_order: ack %0d went to m1 expected m0", got);
        else n_pass++;
        got++;
      end
      tick();
      // Each master drops cyc for one cycle after its ack, then asks again.
      m0_cyc = !a0; m0_stb = !a0;
      m1_cyc = !a1; m1_stb = !a1;
      if (a0) m0_adr = $urandom_range(0, 31);
      if (a1) m1_adr = $urandom_range(32, 63);
      budget--;
    end
    n_checks++;
    if (got < 8) $display("FAIL rr_count: got %0d acks expected 8", got);
    else n_pass++;
    idle_masters();
    tick();
  endtask

  task automatic test_burst();
    logic [DW-1:0] bdat [4];
    int beats, early, budget;
    logic a1;
    do_reset();
    for (int i = 0; i < 4; i++) bdat[i] = $urandom;
    tick();
    m1_cyc = 1; m1_stb = 1; m1_we = 1; m1_sel = 4'hF; m1_adr = 8; m1_datwr = bdat[0];
    tick();
    m0_cyc = 1; m0_stb = 1; m0_adr = 0;
    beats = 0; early = 0; budget = 60;
    while (beats < 4 && budget > 0) begin
      mid();
      a1 = m1_ack;
      if (m0_ack) early++;
      if (a1) beats++;
      tick();
      if (a1 && beats < 4) begin
        m1_adr = 8 + beats;
        m1_datwr = bdat[beats];
      end
      if (beats == 4) begin
        m1_cyc = 0; m1_stb = 0; m1_we = 0;
      end
      budget--;
    end
    n_checks++;
    if (beats != 4 || early != 0)
      $display("FAIL burst_hold: m1 beats %0d m0 early acks %0d expected 4 and 0", beats, early);
    else n_pass++;
    budget = 10;
    while (!m0_ack && budget > 0) begin
      mid();
      if (!m0_ack) begin tick(); budget--; end
    end
    n_checks++;
    if (!m0_ack) $display("FAIL burst_m0_after: got no ack expected ack within 10 cycles");
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (mem[8+i] !== bdat[i]) $display("FAIL burst_beat%0d: got %h expected %h", i, mem[8+i], bdat[i]);
      else n_pass++;
    end
    tick();
    idle_masters();
    tick();
  endtask

  task automatic test_timeout();
    logic [2:0] obs, exp;
    logic       e;
    slv_en = 1'b0;
    tick();
    m0_cyc = 1; m0_stb = 1; m0_adr = 3;
    for (int c = 0; c <= 35; c++) begin
      mid();
      e   = (c == TMO + 1) || (c == 2 * (TMO + 1));
      exp = {e, 1'b0, (c >= 1) && !e};
      obs = {m0_err, m1_err, s_stb};
      n_checks++;
      if (obs !== exp) $display("FAIL timeout_c%0d: got err/err1/stb %b expected %b", c, obs, exp);
      else n_pass++;
      tick();
    end
    idle_masters();
    tick();
    slv_en = 1'b1;
    tick();
  endtask

  task automatic test_async_reset();
    logic [3:0] obs;
    tick();
    m1_cyc = 1; m1_stb = 1; m1_adr = 2;
    tick(); mid();
    n_checks++;
    if ({s_cyc, s_stb} !== 2'b11) $display("FAIL arst_pre: got %b expected 11", {s_cyc, s_stb});
    else n_pass++;
    #1 reset = 1'b0;
    #1;
    obs = {s_cyc, s_stb, m1_ack, m1_err};
    n_checks++;
    if (obs !== 4'b0) $display("FAIL arst_immediate: got %b expected 0000", obs);
    else n_pass++;
    tick();
    idle_masters();
    tick();
    reset = 1'b1;
    tick();
    m0_cyc = 1; m0_stb = 1; m0_adr = 32'h11;
    m1_cyc = 1; m1_stb = 1; m1_adr = 32'h22;
    tick(); mid();
    n_checks++;
    if ({s_cyc, s_adr} !== {1'b1, 32'h11}) $display("FAIL arst_tie: got %b %h expected 1 11", s_cyc, s_adr);
    else n_pass++;
    tick();
    idle_masters();
    tick();
  endtask

  task automatic test_random();
    logic [DW-1:0] ref_mem [64];
    logic          act [2];
    int            left [2];
    logic          rwe [2];
    logic [5:0]    radr [2];
    logic [DW-1:0] rdat [2];
    logic [SW-1:0] rsel [2];
    logic          ackp [2];
    logic          ackn [2];
    logic [DW-1:0] rd;
    int            owner, last, o;
    logic [AW-1:0] exp_adr;
    logic          exp_cyc;
    do_reset();
    for (int i = 0; i < 64; i++) ref_mem[i] = '0;
    for (int m = 0; m < 2; m++) begin act[m] = 0; left[m] = 0; ackp[m] = 0; end
    owner = -1;
    last  = 1;
    for (int cy = 0; cy < 400; cy++) begin
      tick();
      for (int m = 0; m < 2; m++) begin
        if (ackp[m]) begin
          left[m]--;
          if (left[m] == 0) act[m] = 0;
        end else if (!act[m] && ($urandom % 4 == 0)) begin
          act[m]  = 1;
          left[m] = 1 + ($urandom % 3);
        end
        if (act[m] && (ackp[m] || !(m == 0 ? m0_cyc : m1_cyc))) begin
          rwe[m]  = $urandom % 2;
          radr[m] = $urandom;
          rdat[m] = $urandom;
          rsel[m] = $urandom;
        end
      end
      m0_cyc = act[0]; m0_stb = act[0]; m0_we = rwe[0]; m0_adr = {26'd0, radr[0]};
      m0_datwr = rdat[0]; m0_sel = rsel[0];
      m1_cyc = act[1]; m1_stb = act[1]; m1_we = rwe[1]; m1_adr = {26'd0, radr[1]};
      m1_datwr = rdat[1]; m1_sel = rsel[1];
      mid();
      exp_cyc = (owner >= 0) ? act[owner] : 1'b0;
      exp_adr = (owner >= 0) ? {26'd0, radr[owner]} : '0;
      n_checks++;
      if ({s_cyc, s_adr} !== {exp_cyc, exp_adr})
        $display("FAIL rand_mux cy%0d: got %b %h expected %b %h", cy, s_cyc, s_adr, exp_cyc, exp_adr);
      else n_pass++;
      n_checks++;
      if ({m0_err, m1_err, (owner != 0) & m0_ack, (owner != 1) & m1_ack} !== 4'b0)
        $display("FAIL rand_term cy%0d: got err %b%b acks %b%b owner %0d", cy, m0_err, m1_err, m0_ack, m1_ack, owner);
      else n_pass++;
      ackn[0] = m0_ack;
      ackn[1] = m1_ack;
      for (int m = 0; m < 2; m++) begin
        if (ackn[m]) begin
          if (rwe[m]) begin
            for (int b = 0; b < SW; b++)
              if (rsel[m][b]) ref_mem[radr[m]][8*b +: 8] = rdat[m][8*b +: 8];
          end else begin
            rd = (m == 0) ? m0_datrd : m1_datrd;
            n_checks++;
            if (rd !== ref_mem[radr[m]])
              $display("FAIL rand_read m%0d adr %0d: got %h expected %h", m, radr[m], rd, ref_mem[radr[m]]);
            else n_pass++;
          end
        end
        ackp[m] = ackn[m];
      end
      // Ownership for the next cycle, from this cycle's requests.
      if (owner < 0) begin
        if (act[0] && act[1]) owner = (last == 0) ? 1 : 0;
        else if (act[0]) owner = 0;
        else if (act[1]) owner = 1;
      end else if (!act[owner]) begin
        o     = owner;
        last  = o;
        owner = act[1-o] ? 1 - o : -1;
      end
    end
    tick();
    idle_masters();
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    idle_masters();
    test_reset();
    test_single();
    test_simultaneous();
    test_round_robin();
    test_burst();
    test_timeout();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
